ma_channel_scheduler: RTL and testbench
=======================================

# ma_channel_scheduler

Time-multiplexes one 4-tap moving-sum datapath across `CHANNELS` independent sample streams. A round-robin arbiter grants at most one requesting channel per cycle. For the granted channel it computes the sum of the new sample and that channel's 3 stored samples, writes back the shifted history, and presents the result with its channel index on a single output port. The block sits between the per-channel sample sources and the downstream consumer. It replaces one dedicated moving-average instance per channel.

## Interface
- `CHANNELS`, 4: number of requesters; ≥2.
- `SAMPLE_W`, 8: signed sample and result width.
- `system1000` in 1: clock, rising edge.
- `system1000_rstn` in 1: reset, asynchronous, active-low.
- `in_valid` in `CHANNELS`: per-channel sample valid.
- `in_data` in `CHANNELS*SAMPLE_W`: channel i at bits `[i*SAMPLE_W +: SAMPLE_W]`, signed.
- `in_ready` out `CHANNELS`: one-hot grant; the sample is accepted when `in_valid[i] & in_ready[i]`.
- `clear` in 1: synchronous; zeroes all channel histories.
- `out_valid` out 1: result valid.
- `out_data` out `SAMPLE_W`: signed window sum.
- `out_chan` out `$clog2(CHANNELS)`: channel that produced `out_data`.
- `out_ready` in 1: consumer accepts the result when `out_valid & out_ready`.

## Operation
- **History state.** Each channel c has history `h0[c]`, `h1[c]`, `h2[c]`, newest first.
- **Slot free.** The output slot is free when `!out_valid | out_ready`.
- **Grant.** When the slot is free and `clear` is low, the arbiter grants exactly one `i` with `in_valid[i]` set.
  - Round-robin search starts at `(last_granted+1) mod CHANNELS`.
  - `in_ready` = grant. `in_ready` may depend combinationally on `in_valid`, `out_ready` and `clear`.
  - Otherwise `in_ready` is all zero.
- **On an accepted sample x from channel i:**
  - result = `(x + h0[i]) + (h1[i] + h2[i])`, computed modulo 2^SAMPLE_W with two's-complement wrap and no saturation.
  - History update: `h2[i]←h1[i]`, `h1[i]←h0[i]`, `h0[i]←x`.
  - Output register: `out_data←result`, `out_chan←i`, `out_valid←1`.
  - `last_granted←i`.
- **Drain.** If the slot is drained (`out_valid & out_ready`) and there is no new grant, `out_valid←0`. `out_data` and `out_chan` hold their last values.
- **Backpressure.** With `out_valid=1` and `out_ready=0`, `out_data` and `out_chan` remain stable and `in_ready=0`.
- **Clear.**
  - `clear` wins over any request: no grant that cycle.
  - All histories are 0 after the edge.
  - The output register and `last_granted` are unaffected.
- **Async reset.** Asynchronous assertion, at any time including mid-backpressure:
  - `out_valid=0`, `out_data=0`, `out_chan=0`.
  - All histories 0.
  - `last_granted=CHANNELS-1`, so channel 0 has first priority.
  - `in_ready=0` while reset is asserted.

## Timing
- Latency: sample accepted at edge t appears with `out_valid=1` after edge t.
- Throughput: one result per cycle when `out_ready` is held high.
- Each of N continuously valid channels is granted once every N cycles.
- The combinational path `out_ready → in_ready` exists by design; the downstream block must not derive `out_ready` from `in_ready`.
- Same-cycle read-modify-write of one channel's history is impossible, because there is at most one grant per cycle.

## Structure
- Shared package `ma_sched_pkg` holds:
  - `SAMPLE_W` and `TAPS` (=4) constants.
  - `sample_t` (signed `SAMPLE_W`).
  - The function computing the 4-input wrap-around sum, so the standalone moving-average path and this block agree bit-exactly.
- Sub-module `rr_arbiter`:
  - Inputs: parameter `N`, `req[N]`, `enable`.
  - Outputs: one-hot `grant`, encoded `grant_idx`.
  - The pointer update happens inside the sub-module on `enable & |req`.
- Top level contains the history register bank, adder tree, output register and handshake logic.

## Test plan
- **Reset and first sample:** reset, then ch0 sample 5 → next cycle `out_valid=1`, `out_data=5`, `out_chan=0`. All outputs read 0 during reset.
- **Single-channel stream:** ch2 sends 1,2,3,4,5 with `out_ready=1` → outputs 1,3,6,10,14, all with `out_chan=2`.
- **Wrap-around:** ch1 sends 100,100,100 → 100, -56, 44.
- **Fair arbitration:** all 4 channels hold `in_valid` with fixed values 1,2,3,4 → grant order 0,1,2,3,0,… Second-round results are 2,4,6,8, showing the histories are independent.
- **Backpressure:** `out_ready=0` for 3 cycles while all channels are valid → `out_data`/`out_chan` frozen, `in_ready=0`, no sample lost. On release, the sequence resumes in round-robin order.
- **Clear and mid-operation reset:**
  - After ch3 receives 10,20,30, pulse `clear` with ch3 valid → no grant that cycle. Next ch3 sample 7 → `out_data=7`.
  - Asserting reset during backpressure → `out_valid` drops immediately.

Source files
------------

// File: rtl/ma_sched_pkg.sv
// Shared constants, sample type and wrap-around sum for the
// moving-sum datapath and the channel scheduler.
package ma_sched_pkg;

    localparam int SAMPLE_W = 8;
    localparam int TAPS     = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Four-input sum in a 32-bit container. Callers keep the low
    // bits, which gives two's-complement wrap at any width up to 32.
    function automatic logic [31:0] wrap_sum4(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] c,
        input logic [31:0] d
    );
        return (a + b) + (c + d);
    endfunction

    // Same sum on the package sample type, for the standalone path.
    function automatic sample_t sum4(
        input sample_t a,
        input sample_t b,
        input sample_t c,
        input sample_t d
    );
        return sample_t'(wrap_sum4(32'(a), 32'(b), 32'(c), 32'(d)));
    endfunction

endpackage

// File: rtl/ma_channel_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting after the last
// granted requester; the pointer moves only when a grant is given.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 enable,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic          found;
    int            c;

    // Search from last+1 upward with wrap, take the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(last_q) + k) % N;
            if (!found && enable && req[c]) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = IW'(c);
            end
        end
    end

    // Pointer follows the winner so it loses priority next time.
    always_comb begin
        last_d = last_q;
        if (found) begin
            last_d = grant_idx;
        end
    end

    // Reset to N-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ma_channel_scheduler.sv
// Shares one 4-tap moving-sum datapath across several sample
// streams with round-robin grant and a single registered output.
module ma_channel_scheduler #(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 8
) (
    input  logic                         system1000,
    input  logic                         system1000_rstn,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] in_data,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic                         clear,
    output logic                         out_valid,
    output logic [SAMPLE_W-1:0]          out_data,
    output logic [$clog2(CHANNELS)-1:0]  out_chan,
    input  logic                         out_ready
);

    import ma_sched_pkg::*;

    localparam int CW = $clog2(CHANNELS);

    logic                slot_free;
    logic                arb_en;
    logic                accept;
    logic [CHANNELS-1:0] grant;
    logic [CW-1:0]       gidx;
    logic [SAMPLE_W-1:0] x;
    logic [SAMPLE_W-1:0] sum;

    logic [SAMPLE_W-1:0] h0_q [CHANNELS];
    logic [SAMPLE_W-1:0] h1_q [CHANNELS];
    logic [SAMPLE_W-1:0] h2_q [CHANNELS];
    logic [SAMPLE_W-1:0] h0_d [CHANNELS];
    logic [SAMPLE_W-1:0] h1_d [CHANNELS];
    logic [SAMPLE_W-1:0] h2_d [CHANNELS];

    logic                out_valid_q;
    logic                out_valid_d;
    logic [SAMPLE_W-1:0] out_data_q;
    logic [SAMPLE_W-1:0] out_data_d;
    logic [CW-1:0]       out_chan_q;
    logic [CW-1:0]       out_chan_d;

    // No grant while in reset, during clear, or while the slot is held.
    assign slot_free = ~out_valid_q | out_ready;
    assign arb_en    = slot_free & ~clear & system1000_rstn;

    rr_arbiter #(
        .N (CHANNELS)
    ) u_arb (
        .clk       (system1000),
        .rst_n     (system1000_rstn),
        .req       (in_valid),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign accept   = |grant;
    assign in_ready = grant;

    assign x   = in_data[int'(gidx)*SAMPLE_W +: SAMPLE_W];
    assign sum = SAMPLE_W'(wrap_sum4(32'(x),
                                     32'(h0_q[gidx]),
                                     32'(h1_q[gidx]),
                                     32'(h2_q[gidx])));

    // Clear wipes every history; otherwise shift only the winner.
    always_comb begin
        h0_d = h0_q;
        h1_d = h1_q;
        h2_d = h2_q;
        if (clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                h0_d[i] = '0;
                h1_d[i] = '0;
                h2_d[i] = '0;
            end
        end else if (accept) begin
            h2_d[gidx] = h1_q[gidx];
            h1_d[gidx] = h0_q[gidx];
            h0_d[gidx] = x;
        end
    end

    // History bank registers.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                h0_q[i] <= '0;
                h1_q[i] <= '0;
                h2_q[i] <= '0;
            end
        end else begin
            h0_q <= h0_d;
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end

    // Load on accept, drop valid on drain, hold data and channel.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_chan_d  = gidx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_ma_channel_scheduler.sv
// Randomized and directed checks of ma_channel_scheduler against
// a cycle-level reference model of the scheduling rules.
module tb_ma_channel_scheduler;

    localparam int C = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic [C-1:0]   iv;
    logic [C*W-1:0] id;
    logic [C-1:0]   ir;
    logic           clr;
    logic           ov;
    logic [W-1:0]   od;
    logic [1:0]     oc;
    logic           ordy;

    int vectors = 0;
    int errors  = 0;

    int         mh [C][3];
    int         mlast;
    logic       mov;
    logic [W-1:0] mod;
    int         moc;

    always #5 clk = ~clk;

    ma_channel_scheduler #(
        .CHANNELS (C),
        .SAMPLE_W (W)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .in_valid        (iv),
        .in_data         (id),
        .in_ready        (ir),
        .clear           (clr),
        .out_valid       (ov),
        .out_data        (od),
        .out_chan        (oc),
        .out_ready       (ordy)
    );

    task automatic chk(input string n, input int act, input int exp);
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < C; i++)
            for (int j = 0; j < 3; j++) mh[i][j] = 0;
        mlast = C - 1;
        mov   = 1'b0;
        mod   = '0;
        moc   = 0;
    endtask

    function automatic int exp_grant_ch();
        if (!rstn || clr || (mov && !ordy)) return -1;
        for (int k = 1; k <= C; k++) begin
            if (iv[(mlast + k) % C]) return (mlast + k) % C;
        end
        return -1;
    endfunction

    // One cycle: drive after negedge, compare, model the edge.
    task automatic step(input logic [C-1:0] v, input logic [C*W-1:0] d,
                        input logic r, input logic cl);
        int g;
        int s;
        logic [W-1:0] xs;
        logic [C-1:0] eg;
        iv   = v;
        id   = d;
        ordy = r;
        clr  = cl;
        #1;
        g  = exp_grant_ch();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        vectors++;
        chk("in_ready", int'(ir), int'(eg));
        chk("out_valid", int'(ov), int'(mov));
        chk("out_data", int'(od), int'(mod));
        chk("out_chan", int'(oc), moc);
        @(posedge clk);
        if (g >= 0) begin
            xs = d[g*W +: W];
            s  = int'($signed(xs)) + mh[g][0] + mh[g][1] + mh[g][2];
            mod = W'(s);
            moc = g;
            mov = 1'b1;
            mlast = g;
            mh[g][2] = mh[g][1];
            mh[g][1] = mh[g][0];
            mh[g][0] = int'($signed(xs));
        end else if (mov && ordy) begin
            mov = 1'b0;
        end
        if (cl) begin
            for (int i = 0; i < C; i++)
                for (int j = 0; j < 3; j++) mh[i][j] = 0;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset at the current time, outputs checked at once.
    task automatic do_reset();
        iv   = '1;
        ordy = 1'b1;
        clr  = 1'b0;
        rstn = 1'b0;
        #1;
        vectors++;
        chk("rst out_valid", int'(ov), 0);
        chk("rst out_data", int'(od), 0);
        chk("rst out_chan", int'(oc), 0);
        chk("rst in_ready", int'(ir), 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic logic [C*W-1:0] one(input int ch, input int val);
        logic [C*W-1:0] d;
        logic [W-1:0]   b;
        d = '0;
        b = W'(val);
        d[ch*W +: W] = b;
        return d;
    endfunction

    logic [C*W-1:0] all4;
    int stream [5] = '{1, 2, 3, 4, 5};
    int sexp   [5] = '{1, 3, 6, 10, 14};
    int wexp   [3] = '{100, -56, 44};

    initial begin
        iv = '0; id = '0; ordy = 1'b1; clr = 1'b0; rstn = 1'b1;
        @(negedge clk);
        do_reset();

        step(4'b0001, one(0, 5), 1'b1, 1'b0);
        chk("first valid", int'(ov), 1);
        chk("first data", int'(od), 5);
        chk("first chan", int'(oc), 0);

        for (int i = 0; i < 5; i++) begin
            step(4'b0100, one(2, stream[i]), 1'b1, 1'b0);
            chk("stream data", int'($signed(od)), sexp[i]);
            chk("stream chan", int'(oc), 2);
        end

        for (int i = 0; i < 3; i++) begin
            step(4'b0010, one(1, 100), 1'b1, 1'b0);
            chk("wrap data", int'($signed(od)), wexp[i]);
        end

        do_reset();
        all4 = {8'd4, 8'd3, 8'd2, 8'd1};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < C; i++) begin
                step(4'b1111, all4, 1'b1, 1'b0);
                chk("fair chan", int'(oc), i);
                chk("fair data", int'(od), (r + 1) * (i + 1));
            end
        end

        for (int i = 0; i < 3; i++) begin
            step(4'b1111, all4, 1'b0, 1'b0);
            chk("bp data", int'(od), 8);
            chk("bp chan", int'(oc), 3);
        end
        step(4'b1111, all4, 1'b1, 1'b0);
        chk("resume chan", int'(oc), 0);
        chk("resume data", int'(od), 3);

        do_reset();
        step(4'b1000, one(3, 10), 1'b1, 1'b0);
        step(4'b1000, one(3, 20), 1'b1, 1'b0);
        step(4'b1000, one(3, 30), 1'b1, 1'b0);
        chk("pre-clear data", int'(od), 60);
        step(4'b1000, one(3, 99), 1'b1, 1'b1);
        chk("clear no grant", int'(ov), 0);
        step(4'b1000, one(3, 7), 1'b1, 1'b0);
        chk("post-clear data", int'(od), 7);

        step(4'b0001, one(0, 9), 1'b0, 1'b0);
        chk("bp hold valid", int'(ov), 1);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                do_reset();
            end else begin
                step(C'($urandom), $urandom,
                     ($urandom_range(0, 9) < 7),
                     ($urandom_range(0, 19) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
